// File: rtl/instr_fetch_unit_if.sv
// Line-read bus between the instruction fetch unit (master) and the memory side (slave):
// a request/ack address phase followed by a burst of 64-bit response beats.
interface instr_fetch_unit_if;
    logic        req_cyc;
    logic [63:0] req_addr;
    logic        req_ack;
    logic        resp_cyc;
    logic [63:0] resp_data;
    logic        resp_ack;

    modport master (
        output req_cyc,
        output req_addr,
        input  req_ack,
        input  resp_cyc,
        input  resp_data,
        output resp_ack
    );

    modport slave (
        input  req_cyc,
        input  req_addr,
        output req_ack,
        output resp_cyc,
        output resp_data,
        input  resp_ack
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: streams bus lines into a circular byte buffer and presents a
// WINDOW-byte decode window at the current instruction pointer (win_rip).
module instr_fetch_unit #(
    parameter int unsigned LINE_BYTES = 64,
    parameter int unsigned BUF_BYTES  = 128,
    parameter int unsigned WINDOW     = 15,
    localparam int unsigned CW        = $clog2(WINDOW + 1),
    localparam int unsigned OW        = $clog2(BUF_BYTES) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [63:0]           entry,
    input  logic                  redirect_valid,
    input  logic [63:0]           redirect_addr,
    instr_fetch_unit_if.master    bus,
    output logic                  win_valid,
    output logic [WINDOW*8-1:0]   win_bytes,
    output logic [63:0]           win_rip,
    input  logic [CW-1:0]         consume,
    output logic [OW-1:0]         occupancy
);
    localparam int unsigned PW    = $clog2(BUF_BYTES);
    localparam int unsigned LW    = $clog2(LINE_BYTES);
    localparam int unsigned BEATS = LINE_BYTES / 8;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StWait   = 2'd1;
    localparam logic [1:0] StActive = 2'd2;
    localparam logic [1:0] StDrain  = 2'd3;

    localparam logic [LW-1:0] LastBeat  = LW'(BEATS - 1);
    localparam logic [LW:0]   BeatBytes = (LW + 1)'(8);

    logic [1:0]    state_q, state_d;
    logic          req_cyc_q, req_cyc_d;
    logic [63:0]   fetch_addr_q, fetch_addr_d;
    logic [LW-1:0] skip_q, skip_d;
    logic [LW-1:0] beat_cnt_q, beat_cnt_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [OW-1:0] occ_q, occ_d;
    logic [63:0]   rip_q, rip_d;
    logic [7:0]    buf_q [BUF_BYTES];

    logic          beat_take;
    logic          beat_last;
    logic          line_done;
    logic          fill;
    logic [LW-1:0] beat_off;
    logic [LW:0]   skip_rem;
    logic [3:0]    first;
    logic [3:0]    n_wr;
    logic [CW-1:0] n_rd;

    assign bus.resp_ack = bus.resp_cyc;
    assign bus.req_cyc  = req_cyc_q;
    assign bus.req_addr = fetch_addr_q & ~(64'(LINE_BYTES) - 64'd1);

    assign win_valid = (occ_q >= OW'(WINDOW)) && !(state_q == StDrain && occ_q == '0);
    assign win_rip   = rip_q;
    assign occupancy = occ_q;

    // Any beat seen outside IDLE belongs to the single outstanding line.
    assign beat_take = bus.resp_cyc && (state_q != StIdle);
    assign beat_last = beat_cnt_q == LastBeat;
    assign line_done = beat_take && beat_last && (state_q == StWait || state_q == StActive);
    assign fill      = beat_take && !redirect_valid && (state_q != StDrain);
    assign beat_off  = beat_cnt_q << 3;
    assign skip_rem  = {1'b0, skip_q} - {1'b0, beat_off};

    // Skipped bytes form a prefix of the line, so the kept part of a beat is a suffix.
    always_comb begin
        first = 4'd0;
        if (skip_q > beat_off) begin
            first = (skip_rem >= BeatBytes) ? 4'd8 : 4'(skip_rem);
        end
    end

    assign n_wr = fill ? (4'd8 - first) : 4'd0;
    assign n_rd = (win_valid && !redirect_valid) ? consume : '0;

    always_comb begin
        win_bytes = '0;
        for (int k = 0; k < int'(WINDOW); k++) begin
            win_bytes[8*k +: 8] = buf_q[rd_ptr_q + PW'(k)];
        end
    end

    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        fetch_addr_d = fetch_addr_q;
        skip_d       = skip_q;

        if (beat_take) begin
            beat_cnt_d = beat_last ? '0 : beat_cnt_q + 1'b1;
        end

        unique case (state_q)
            StIdle:            if (req_cyc_q && bus.req_ack) state_d = StWait;
            StWait:            if (beat_take) state_d = beat_last ? StIdle : StActive;
            StActive, StDrain: if (beat_take && beat_last) state_d = StIdle;
            default:           state_d = StIdle;
        endcase

        if (line_done) begin
            fetch_addr_d = fetch_addr_q + 64'(LINE_BYTES);
            skip_d       = '0;
        end

        // A line still owed by the bus after this cycle must be drained before refetching.
        if (redirect_valid) begin
            fetch_addr_d = redirect_addr;
            skip_d       = redirect_addr[LW-1:0];
            if (state_d != StIdle) begin
                state_d = StDrain;
            end
        end

        if (redirect_valid) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
            rip_d    = redirect_addr;
        end else begin
            wr_ptr_d = wr_ptr_q + PW'(n_wr);
            rd_ptr_d = rd_ptr_q + PW'(n_rd);
            occ_d    = occ_q + OW'(n_wr) - OW'(n_rd);
            rip_d    = rip_q + 64'(n_rd);
        end

        req_cyc_d = (state_d == StIdle) && !redirect_valid &&
                    (OW'(BUF_BYTES) - occ_d >= OW'(LINE_BYTES));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            req_cyc_q    <= 1'b0;
            fetch_addr_q <= entry;
            skip_q       <= entry[LW-1:0];
            beat_cnt_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            rip_q        <= entry;
        end else begin
            state_q      <= state_d;
            req_cyc_q    <= req_cyc_d;
            fetch_addr_q <= fetch_addr_d;
            skip_q       <= skip_d;
            beat_cnt_q   <= beat_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            rip_q        <= rip_d;
        end
    end

    // Byte storage needs no reset; occupancy alone defines which bytes are live.
    always_ff @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 8; i++) begin
                if (4'(i) >= first) begin
                    buf_q[wr_ptr_q + PW'(4'(i) - first)] <= bus.resp_data[8*i +: 8];
                end
            end
        end
    end

    a_consume_range: assert property (@(posedge clk) disable iff (reset)
        consume <= CW'(WINDOW));
    a_occ_bound: assert property (@(posedge clk) disable iff (reset)
        occ_q <= OW'(BUF_BYTES));
    a_no_beat_idle: assert property (@(posedge clk) disable iff (reset)
        !(bus.resp_cyc && state_q == StIdle));
endmodule
